sprite_index_pipe: RTL and testbench
====================================

# sprite_index_pipe

- Per-pixel palette-index generator sitting directly upstream of the palette (index→RGB) stage.
- Takes the VGA scan position and a background tile index, and composites one animated, optionally mirrored sprite over it.
- Sprite pixels are read from an external synchronous sprite ROM.
- Emits one 8-bit palette index per clock with a fixed 2-cycle latency.

## Interface
Parameters:
- SPR_W, 16: sprite width in pixels (power of two)
- SPR_H, 16: sprite height in pixels (power of two)
- FRAMES, 4: animation frames stored consecutively in ROM (power of two)
- ANIM_DIV, 8: vsync_start pulses per animation step (≥1)
- ROM_AW, 10: ROM address width; must be ≥ log2(FRAMES·SPR_W·SPR_H)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- draw_x  in  10  current scan column
- draw_y  in  10  current scan row
- pix_valid  in  1  draw_x/draw_y lie in the active video area
- vsync_start  in  1  one-cycle pulse at the start of vertical blank
- bg_index  in  8  background palette index for (draw_x, draw_y), same cycle
- sprite_x_in  in  10  sprite top-left column (shadow input)
- sprite_y_in  in  10  sprite top-left row (shadow input)
- sprite_en_in  in  1  sprite visible (shadow input)
- sprite_flip_in  in  1  horizontal mirror (shadow input)
- rom_addr  out  ROM_AW  sprite ROM address, registered
- rom_data  in  8  ROM palette index, valid one cycle after rom_addr
- index_out  out  8  composited palette index to the palette stage
- index_valid  out  1  index_out corresponds to an active pixel

## Operation
- **Shadow latch.** The sprite_*_in inputs are ignored except on vsync_start. On that cycle, all four are copied into active registers (sx, sy, en, flip).
  - Position changes therefore take effect only at frame boundaries.
- **Animation counter.** A divider counts vsync_start pulses from 0 to ANIM_DIV-1.
  - On wrap, anim_frame increments modulo FRAMES (FRAMES-1 → 0).
- **Stage 0** (registered on the cycle the inputs are presented):
  - hit = en && pix_valid && draw_x ≥ sx && draw_x < sx+SPR_W && draw_y ≥ sy && draw_y < sy+SPR_H.
  - All comparisons use 11-bit zero-extended arithmetic, so sx+SPR_W > 1023 never wraps. A sprite partly off-screen clips and never aliases to column 0.
  - col = draw_x−sx (low log2 SPR_W bits); when flip=1, col = SPR_W−1−col.
  - row = draw_y−sy.
  - rom_addr ← anim_frame·SPR_W·SPR_H + row·SPR_W + col.
  - rom_addr is updated only when hit=1 and holds its previous value otherwise.
  - hit, bg_index and pix_valid are registered alongside (hit_d1, bg_d1, valid_d1).
- **Stage 1:**
  - index_out ← 8'd1 (black) if !valid_d1.
  - Otherwise index_out ← rom_data if hit_d1 && rom_data ≠ 0, else bg_d1.
  - index_valid ← valid_d1.
  - Palette index 0 is the transparent key and is never emitted for a sprite pixel.
  - bg_index = 0 passes through unchanged; the palette stage renders it as its key colour.

## Timing
- **Latency:** inputs at cycle n → index_out/index_valid at the rising edge ending cycle n+1, i.e. 2 registered stages. The palette stage then samples index_out on the next falling edge.
- **Throughput:** one pixel per clock, no stalls, no backpressure.
- **Reset values:**
  - Outputs: rom_addr=0, index_out=8'd1, index_valid=0.
  - Internal: sx=sy=0, en=0, flip=0, anim_frame=0, divider=0, hit_d1=0, valid_d1=0.
- **Reset mid-frame:** pipeline flushed. index_valid stays 0 on the first cycle after reset deasserts and follows pix_valid from the second cycle on.
- **vsync_start coincident with pix_valid=1:** that pixel uses the old active registers. The new values apply from the next cycle.
- **vsync_start coincident with reset:** reset wins; nothing is latched.
- **Divider:** anim_frame changes on the same edge as the vsync_start that completes the ANIM_DIV count.
- **Edge columns:** draw_x = sx is a hit; draw_x = sx+SPR_W is not. Rows behave the same way.

## Test plan
- **Reset:** hold reset 3 cycles with pix_valid=1 → index_out=1, index_valid=0 throughout and on the first cycle after release.
- **Background pass-through:** en latched 0, pix_valid=1, bg_index=7 at n → index_out=7, index_valid=1 at n+2; rom_addr unchanged.
- **Opaque hit:**
  - Setup: sprite at (100,50) latched on vsync_start, anim_frame 0, flip=0.
  - Stimulus: pixel (103,52); ROM model returns 8'd10.
  - Response: rom_addr=2·16+3=35; index_out=10 two cycles later.
  - Same pixel with rom_data=0 → index_out=bg_index.
- **Flip and clipping:**
  - flip=1, pixel (100,50) → col=15, rom_addr=15.
  - sx=1020: pixels 1020..1023 hit, column 0 never hits.
  - draw_x=sx+16 → background.
- **Animation and shadow timing:**
  - With ANIM_DIV=8, 8 vsync_start pulses advance anim_frame to 1; rom_addr for (sx,sy) becomes 256.
  - 32 pulses wrap anim_frame to 0.
  - Changing sprite_x_in mid-frame has no effect until the next vsync_start.

Source files
------------

// File: rtl/sprite_index_pipe.sv
// sprite_index_pipe: composites one animated, optionally mirrored sprite over
// a background tile index. Two registered stages: ROM address/hit, then mux.
module sprite_index_pipe #(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  parameter int ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              pix_valid,
  input  logic              vsync_start,
  input  logic [7:0]        bg_index,
  input  logic [9:0]        sprite_x_in,
  input  logic [9:0]        sprite_y_in,
  input  logic              sprite_en_in,
  input  logic              sprite_flip_in,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        index_out,
  output logic              index_valid
);

  localparam int FW = (FRAMES   > 1) ? $clog2(FRAMES)   : 1;
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // Active sprite registers, only loaded at frame boundaries
  logic [9:0]    sx, sy;
  logic          en, flip;
  logic [FW-1:0] anim_frame;
  logic [DW-1:0] divider;

  // Stage 0 -> stage 1 side-band
  logic          hit_d1, valid_d1;
  logic [7:0]    bg_d1;

  // Stage 0 combinational geometry
  logic [10:0]       x_end, y_end;
  logic              hit;
  logic [9:0]        dx, dy, col, row;
  logic [ROM_AW-1:0] addr_nxt;

  // Bounds use an 11-bit right edge so a sprite near column 1023 clips
  // instead of wrapping round to column 0.
  always_comb begin
    x_end = {1'b0, sx} + 11'(SPR_W);
    y_end = {1'b0, sy} + 11'(SPR_H);
    hit   = en && pix_valid &&
            (draw_x >= sx) && ({1'b0, draw_x} < x_end) &&
            (draw_y >= sy) && ({1'b0, draw_y} < y_end);
    dx    = draw_x - sx;
    dy    = draw_y - sy;
    col   = dx & 10'(SPR_W - 1);
    if (flip) col = 10'(SPR_W - 1) - col;
    row   = dy & 10'(SPR_H - 1);
    addr_nxt = ROM_AW'(anim_frame) * ROM_AW'(SPR_W * SPR_H)
             + ROM_AW'(row) * ROM_AW'(SPR_W)
             + ROM_AW'(col);
  end

  // Shadow latch and animation divider, both advanced by vsync_start
  always_ff @(posedge clk) begin
    if (reset) begin
      sx         <= '0;
      sy         <= '0;
      en         <= 1'b0;
      flip       <= 1'b0;
      divider    <= '0;
      anim_frame <= '0;
    end else if (vsync_start) begin
      sx   <= sprite_x_in;
      sy   <= sprite_y_in;
      en   <= sprite_en_in;
      flip <= sprite_flip_in;
      if (divider == DW'(ANIM_DIV - 1)) begin
        divider    <= '0;
        anim_frame <= (anim_frame == FW'(FRAMES - 1)) ? '0 : anim_frame + FW'(1);
      end else begin
        divider <= divider + DW'(1);
      end
    end
  end

  // Stage 0: issue ROM address on a hit, carry hit/bg/valid alongside
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      valid_d1 <= 1'b0;
      bg_d1    <= '0;
    end else begin
      if (hit) rom_addr <= addr_nxt;
      hit_d1   <= hit;
      valid_d1 <= pix_valid;
      bg_d1    <= bg_index;
    end
  end

  // Stage 1: ROM index 0 is transparent and falls through to background
  always_ff @(posedge clk) begin
    if (reset) begin
      index_out   <= 8'd1;
      index_valid <= 1'b0;
    end else begin
      if (!valid_d1)                   index_out <= 8'd1;
      else if (hit_d1 && rom_data != 0) index_out <= rom_data;
      else                              index_out <= bg_d1;
      index_valid <= valid_d1;
    end
  end

endmodule

// File: tb/tb_sprite_index_pipe.sv
// Bench for sprite_index_pipe: directed scenarios plus a randomized run
// against a frame-level reference model of the compositor.
module tb_sprite_index_pipe;

  localparam int SW = 16, SH = 16, NF = 4, AD = 8, AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    draw_x, draw_y;
  logic          pix_valid, vsync_start;
  logic [7:0]    bg_index;
  logic [9:0]    sprite_x_in, sprite_y_in;
  logic          sprite_en_in, sprite_flip_in;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    index_out;
  logic          index_valid;

  logic [7:0] rom [0:1023];
  assign rom_data = rom[rom_addr];

  sprite_index_pipe #(.SPR_W(SW), .SPR_H(SH), .FRAMES(NF), .ANIM_DIV(AD), .ROM_AW(AW)) dut (
    .clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .pix_valid(pix_valid), .vsync_start(vsync_start), .bg_index(bg_index),
    .sprite_x_in(sprite_x_in), .sprite_y_in(sprite_y_in),
    .sprite_en_in(sprite_en_in), .sprite_flip_in(sprite_flip_in),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .index_out(index_out), .index_valid(index_valid)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model state: sprite registers and a running vsync count
  int m_sx, m_sy, m_en, m_flip, m_vs, m_addr;
  int pend_idx, pend_vld;
  int exp_idx, exp_vld, exp_addr;

  // Present one pixel for one clock, advance the model, sample #1 after edge.
  // exp_addr follows this pixel; exp_idx/exp_vld follow the previous pixel.
  task automatic drive(input bit rst, input int x, input int y, input bit pv,
                       input bit vs, input int bg);
    int frame, col, row, idx;
    bit hit;
    reset = rst; draw_x = 10'(x); draw_y = 10'(y); pix_valid = pv;
    vsync_start = vs; bg_index = 8'(bg);
    if (rst) begin
      m_sx = 0; m_sy = 0; m_en = 0; m_flip = 0; m_vs = 0; m_addr = 0;
      exp_idx = 1; exp_vld = 0; exp_addr = 0; pend_idx = 1; pend_vld = 0;
    end else begin
      frame = (m_vs / AD) % NF;
      hit = (m_en != 0) && pv && x >= m_sx && x < m_sx + SW && y >= m_sy && y < m_sy + SH;
      if (hit) begin
        col = x - m_sx;
        if (m_flip != 0) col = SW - 1 - col;
        row = y - m_sy;
        m_addr = frame * SW * SH + row * SW + col;
      end
      if (!pv) idx = 1;
      else if (hit && rom[m_addr] != 0) idx = rom[m_addr];
      else idx = bg;
      exp_idx = pend_idx; exp_vld = pend_vld; exp_addr = m_addr;
      pend_idx = idx; pend_vld = pv;
      if (vs) begin
        m_sx = sprite_x_in; m_sy = sprite_y_in;
        m_en = sprite_en_in; m_flip = sprite_flip_in; m_vs++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    sprite_x_in = 10'd0; sprite_y_in = 10'd0; sprite_en_in = 1'b1; sprite_flip_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 5, 1, 1, 9);
      tests++;
      if (index_out !== 8'd1 || index_valid !== 1'b0 || rom_addr !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: idx=%0d vld=%0b addr=%0d want 1/0/0", i, index_out, index_valid, rom_addr);
      end
    end
    drive(0, 5, 5, 1, 0, 9);
    tests++;
    if (index_valid !== 1'b0 || index_out !== 8'd1) begin
      fails++;
      $display("FAIL reset_release1: idx=%0d vld=%0b want 1/0", index_out, index_valid);
    end
    drive(0, 6, 5, 1, 0, 9);
    tests++;
    if (index_valid !== 1'b1 || index_out !== 8'd9) begin
      fails++;
      $display("FAIL reset_release2: idx=%0d vld=%0b want 9/1", index_out, index_valid);
    end
  endtask

  task automatic test_bg_pass;
    int a0;
    sprite_en_in = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    a0 = exp_addr;
    drive(0, 3, 3, 1, 0, 7);
    drive(0, 4, 3, 0, 0, 0);
    tests++;
    if (index_out !== 8'd7 || index_valid !== 1'b1 || rom_addr !== AW'(a0)) begin
      fails++;
      $display("FAIL bg_pass: idx=%0d vld=%0b addr=%0d want 7/1/%0d", index_out, index_valid, rom_addr, a0);
    end
  endtask

  task automatic test_opaque_hit;
    drive(1, 0, 0, 0, 0, 0);
    sprite_x_in = 10'd100; sprite_y_in = 10'd50; sprite_en_in = 1'b1; sprite_flip_in = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    rom[35] = 8'd10;
    drive(0, 103, 52, 1, 0, 3);
    tests++;
    if (rom_addr !== 10'd35) begin
      fails++;
      $display("FAIL hit_addr: addr=%0d want 35", rom_addr);
    end
    drive(0, 0, 0, 0, 0, 0);
    tests++;
    if (index_out !== 8'd10 || index_valid !== 1'b1) begin
      fails++;
      $display("FAIL hit_idx: idx=%0d vld=%0b want 10/1", index_out, index_valid);
    end
    rom[35] = 8'd0;
    drive(0, 103, 52, 1, 0, 44);
    drive(0, 0, 0, 0, 0, 0);
    tests++;
    if (index_out !== 8'd44) begin
      fails++;
      $display("FAIL hit_transparent: idx=%0d want 44", index_out);
    end
    rom[35] = 8'd10;
  endtask

  task automatic test_flip_clip;
    int xs [7] = '{1020, 1021, 1022, 1023, 0, 5, 5};
    sprite_x_in = 10'd100; sprite_y_in = 10'd50; sprite_flip_in = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 100, 50, 1, 0, 200);
    tests++;
    if (rom_addr !== 10'd15) begin
      fails++;
      $display("FAIL flip_addr: addr=%0d want 15", rom_addr);
    end
    drive(0, 116, 50, 1, 0, 200);
    tests++;
    if (rom_addr !== 10'd15) begin
      fails++;
      $display("FAIL right_edge_hold: addr=%0d want 15", rom_addr);
    end
    drive(0, 0, 0, 0, 0, 0);
    tests++;
    if (index_out !== 8'd200) begin
      fails++;
      $display("FAIL right_edge_bg: idx=%0d want 200", index_out);
    end
    sprite_x_in = 10'd1020; sprite_flip_in = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      drive(0, xs[i], 50, i < 5, 0, 150 + i);
      tests++;
      if (index_out !== 8'(exp_idx) || index_valid !== exp_vld[0] || rom_addr !== AW'(exp_addr)) begin
        fails++;
        $display("FAIL clip x=%0d: idx=%0d vld=%0b addr=%0d want %0d/%0d/%0d",
                 xs[i], index_out, index_valid, rom_addr, exp_idx, exp_vld, exp_addr);
      end
      if (i == 5) begin
        tests++;
        if (index_out !== 8'd154) begin
          fails++;
          $display("FAIL clip_col0: idx=%0d want 154", index_out);
        end
      end
    end
  endtask

  task automatic test_anim_shadow;
    drive(1, 0, 0, 0, 0, 0);
    sprite_x_in = 10'd200; sprite_y_in = 10'd100; sprite_en_in = 1'b1; sprite_flip_in = 1'b0;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 0);
    drive(0, 200, 100, 1, 0, 0);
    tests++;
    if (rom_addr !== 10'd256) begin
      fails++;
      $display("FAIL anim_frame1: addr=%0d want 256", rom_addr);
    end
    for (int i = 0; i < 24; i++) drive(0, 0, 0, 0, 1, 0);
    drive(0, 200, 100, 1, 0, 0);
    tests++;
    if (rom_addr !== 10'd0) begin
      fails++;
      $display("FAIL anim_wrap: addr=%0d want 0", rom_addr);
    end
    sprite_x_in = 10'd300;
    drive(0, 201, 100, 1, 0, 0);
    tests++;
    if (rom_addr !== 10'd1) begin
      fails++;
      $display("FAIL shadow_hold: addr=%0d want 1", rom_addr);
    end
    drive(0, 202, 100, 1, 1, 0);
    tests++;
    if (rom_addr !== 10'd2) begin
      fails++;
      $display("FAIL vsync_same_cycle: addr=%0d want 2", rom_addr);
    end
    drive(0, 301, 101, 1, 0, 0);
    tests++;
    if (rom_addr !== 10'd17) begin
      fails++;
      $display("FAIL shadow_apply: addr=%0d want 17", rom_addr);
    end
  endtask

  task automatic test_random;
    int x, y;
    bit rst, vs, pv;
    for (int i = 0; i < 256; i++) rom[i * 4 + ($urandom % 4)] = 8'd0;
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 300) == 0;
      vs  = ($urandom % 30) == 0;
      pv  = ($urandom % 8) != 0;
      sprite_x_in    = 10'($urandom);
      sprite_y_in    = 10'($urandom);
      sprite_en_in   = ($urandom % 4) != 0;
      sprite_flip_in = 1'($urandom);
      x = (m_sx + $urandom_range(0, 23) + 1020) % 1024;
      y = (m_sy + $urandom_range(0, 23) + 1020) % 1024;
      drive(rst, x, y, pv, vs, $urandom % 256);
      tests++;
      if (index_out !== 8'(exp_idx) || index_valid !== exp_vld[0] || rom_addr !== AW'(exp_addr)) begin
        fails++;
        $display("FAIL random cyc %0d: idx=%0d vld=%0b addr=%0d want %0d/%0d/%0d",
                 i, index_out, index_valid, rom_addr, exp_idx, exp_vld, exp_addr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom_range(1, 255));
    test_reset();
    test_bg_pass();
    test_opaque_hit();
    test_flip_clip();
    test_anim_shadow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
